// File: rtl/gate_vec_checker.sv
// rtl/gate_vec_checker.sv - clocked stimulus/response checker for the AND/OR/NOT-a/NOT-b gate set
// Define GATE_VEC_CHECKER_STOP_ON_FAIL_EN to end the sequence at the first failing vector.
module gate_vec_checker #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             obs_and,
  input  logic             obs_or,
  input  logic             obs_not_a,
  input  logic             obs_not_b,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_map
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t            state_q;
  logic [1:0]        vec_q;
  logic [HC_W-1:0]   hold_cnt_q;
  logic              a_q, b_q, busy_q, done_q, pass_q;
  logic [ERR_W-1:0]  err_q;
  logic [3:0]        fail_q;

  logic [3:0]        exp_bits, obs_bits;
  logic              mismatch, sample, last_d;
  logic [ERR_W-1:0]  err_d;
  logic [3:0]        fail_d;

  always_comb begin
    exp_bits = {a_q & b_q, a_q | b_q, ~a_q, ~b_q};
    obs_bits = {obs_and, obs_or, obs_not_a, obs_not_b};
    mismatch = (obs_bits != exp_bits);
    sample   = (hold_cnt_q == HOLD_LAST);
    err_d    = err_q;
    fail_d   = fail_q;
    if (mismatch) begin
      err_d  = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
      fail_d = fail_q | (4'b0001 << vec_q);
    end
`ifdef GATE_VEC_CHECKER_STOP_ON_FAIL_EN
    last_d = (vec_q == 2'd3) || mismatch;
`else
    last_d = (vec_q == 2'd3);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vec_q      <= 2'd0;
      hold_cnt_q <= '0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_q     <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_DRIVE;
            vec_q      <= 2'd0;
            hold_cnt_q <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fail_q     <= 4'd0;
          end
        end
        S_DRIVE: begin
          // start is deliberately ignored here; only the hold window advances
          if (sample) begin
            err_q      <= err_d;
            fail_q     <= fail_d;
            hold_cnt_q <= '0;
            if (last_d) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              vec_q      <= vec_q + 2'd1;
              {a_q, b_q} <= vec_q + 2'd1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_map  = fail_q;

endmodule

// File: doc/gate_vec_checker.md
Name: gate_vec_checker

Overview:
- Self-checking stimulus/response stage for the 2-input basic-gate set (AND, OR, NOT a, NOT b).
- Upstream side: drives the gate block's a/b inputs through all four input vectors (00, 01, 10, 11), holding each for a programmable number of cycles.
- Downstream side: samples the four gate outputs at the end of each hold window, compares them against the expected truth table, and accumulates a pass/fail result.
- Replaces hand-written delay-based stimulus with a synthesizable, clocked sequence.

Parameters:
- HOLD_CYCLES, 4, cycles each vector is held before sampling; legal range >= 1.
- ERR_W, 3, width of the saturating error counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a sequence; sampled only in IDLE or DONE.
- obs_and  input  1  observed AND output of the gate block.
- obs_or  input  1  observed OR output.
- obs_not_a  input  1  observed NOT(a) output.
- obs_not_b  input  1  observed NOT(b) output.
- a  output  1  stimulus a to the gate block.
- b  output  1  stimulus b to the gate block.
- busy  output  1  high while in DRIVE.
- done  output  1  high in DONE; pass, err_count and fail_map are valid.
- pass  output  1  1 when err_count==0 at completion.
- err_count  output  ERR_W  number of failing vectors, saturating at 2^ERR_W-1.
- fail_map  output  4  bit v set if vector v failed.

Behaviour:
- One clock domain; one synchronous, active-high reset; no asynchronous logic. All outputs are registered.
- Reset (any state, including mid-sequence) takes effect at the next clk edge: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_map=0, vec=0, hold_cnt=0.
- States: IDLE, DRIVE, DONE.
- IDLE: on start=1 at edge E0:
  - go to DRIVE; vec=0, hold_cnt=0, a=0, b=0.
  - clear err_count and fail_map; busy=1.
- DRIVE: {a,b} = vec[1:0]; hold_cnt increments each cycle.
  - Sample edge: the edge at which hold_cnt==HOLD_CYCLES-1. Vector v is sampled at edge E0+(v+1)*HOLD_CYCLES.
  - At the sample edge, compare {obs_and,obs_or,obs_not_a,obs_not_b} against expected {a&b, a|b, ~a, ~b}.
  - On any bit mismatch: set fail_map[vec] and increment err_count. If err_count is already at max, it holds.
  - At the same sample edge: hold_cnt resets to 0. If vec<3, vec increments and the new a/b drive from the next cycle. If vec==3, go to DONE.
- DONE, entered at edge E0+4*HOLD_CYCLES:
  - done=1, busy=0, pass=(err_count==0).
  - a/b hold their last value (1,1).
  - Remains in DONE until reset or start.
- start in DONE: behaves exactly as start in IDLE. Done drops and a new sequence begins at that edge.
- start while in DRIVE: ignored; no restart and no effect on counters.
- HOLD_CYCLES==1: every DRIVE cycle is a sample edge; a full sequence takes 4 cycles.
- Total sequence latency from the start edge to done=1 is exactly 4*HOLD_CYCLES cycles.
- obs_* inputs are treated as combinational functions of a/b. The gate block must settle within the hold window; sampling the current a/b is correct because a/b are stable for the whole window.

Optional Feature:
- Macro: GATE_VEC_CHECKER_STOP_ON_FAIL_EN.
- Defined: the first mismatching sample edge moves the state directly to DONE after updating fail_map/err_count. err_count is then at most 1, and the remaining vectors are not driven.
- Undefined: all four vectors are always run, regardless of failures.

Test Plan:
- Correct gate model, HOLD_CYCLES=4, start pulse at edge E0:
  - a/b step 00, 01, 10, 11 every 4 cycles.
  - done=1 at E0+16; pass=1, err_count=0, fail_map=0000.
- obs_and stuck at 0 -> only vector 3 fails: err_count=1, fail_map=1000, pass=0.
- obs_not_a and obs_not_b tied to a and b (non-inverted) -> all vectors fail: err_count=4, fail_map=1111.
- Same all-fail stimulus with ERR_W=2 -> err_count saturates at 3; fail_map=1111. With STOP_ON_FAIL_EN defined -> done at E0+4, err_count=1, fail_map=0001.
- start pulsed again at E0+6 during DRIVE -> ignored, done still at E0+16. start pulsed in DONE -> err_count/fail_map clear and the sequence reruns.
- rst asserted at E0+9 (mid-vector 2) -> next edge: all outputs at their reset values. A subsequent start runs a full clean sequence.
